current_sampler: RTL

CURRENT_SAMPLER -- requirements
Module: current_sampler

---
 rtl/current_sampler.sv | 92 +++++++++
 1 files changed

// File: rtl/current_sampler.sv
// current_sampler: per control tick, settles then converts N_CH ADC channels and publishes them atomically.
module current_sampler #(
    parameter int N_CH = 3,
    parameter int DATA_W = 12,
    parameter int SETTLE_CYC = 50,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     ctrl_clk,
    output logic                     adc_start,
    output logic [1:0]               adc_ch,
    input  logic                     adc_done,
    input  logic [DATA_W-1:0]        adc_data,
    output logic [N_CH*DATA_W-1:0]   samples,
    output logic                     sample_valid,
    input  logic                     clr_err,
    output logic                     timeout_err,
    output logic                     overrun_err
);
    typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, DONE} state_t;
    localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [1:0] idx;
    logic [N_CH*DATA_W-1:0] shadow;
    logic [N_CH*DATA_W-1:0] merged;
    logic last;
    assign last = idx == 2'(N_CH - 1);
    for (genvar k = 0; k < N_CH; k++) begin : g_merge
        assign merged[k*DATA_W +: DATA_W] = (idx == 2'(k)) ? adc_data : shadow[k*DATA_W +: DATA_W];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            adc_start <= 1'b0;
            adc_ch <= '0;
            shadow <= '0;
            samples <= '0;
            sample_valid <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            adc_start <= 1'b0;
            sample_valid <= 1'b0;
            overrun_err <= (ctrl_clk && state != IDLE) ? 1'b1 : clr_err ? 1'b0 : overrun_err;
            if (clr_err) timeout_err <= 1'b0;
            case (state)
                IDLE: if (ctrl_clk && en) begin
                    state <= SETTLE;
                    cnt <= CNT_W'(SETTLE_CYC - 1);
                    idx <= '0;
                end
                SETTLE: if (cnt == '0) begin
                    state <= START;
                    adc_start <= 1'b1;
                    adc_ch <= idx;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                START: begin
                    state <= WAIT;
                    cnt <= CNT_W'(TIMEOUT_CYC - 1);
                end
                WAIT: if (adc_done) begin
                    shadow <= merged;
                    if (last) begin
                        state <= DONE;
                        samples <= merged;
                        sample_valid <= 1'b1;
                    end else begin
                        state <= START;
                        idx <= idx + 2'd1;
                        adc_start <= 1'b1;
                        adc_ch <= idx + 2'd1;
                    end
                end else if (cnt == '0) begin
                    state <= IDLE;
                    timeout_err <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
